// File: rtl/soccer_pkg.sv
// Shared soccer-game types and field constants for the CPU opponent logic.
package soccer_pkg;

    localparam int unsigned POS_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        CHASE  = 2'd2,
        RETURN = 2'd3
    } cpu_state_t;

    // Key bit offsets relative to the player's KEY_SHIFT base
    localparam int unsigned KEY_D = 0;
    localparam int unsigned KEY_S = 1;
    localparam int unsigned KEY_A = 2;
    localparam int unsigned KEY_W = 3;

    localparam int unsigned FIELD_HALF_X = 320;
    localparam int unsigned DEF_HOME_X   = 430;
    localparam int unsigned DEF_HOME_Y   = 240;

endpackage

// File: rtl/axis_steer.sv
// Single-axis steering: flags whether the target lies beyond the deadband
// above (inc) or below (dec) the current position.
module axis_steer #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] target,
    input  logic [W-1:0] self,
    input  logic [W-1:0] deadband,
    output logic         inc,
    output logic         dec
);

    logic [W:0] target_w;
    logic [W:0] self_w;
    logic [W:0] dead_w;

    // One extra bit so position+deadband never wraps
    assign target_w = {1'b0, target};
    assign self_w   = {1'b0, self};
    assign dead_w   = {1'b0, deadband};

    assign inc = target_w > (self_w + dead_w);
    assign dec = (target_w + dead_w) < self_w;

endmodule

// File: rtl/cpu_player_driver.sv
// CPU opponent: periodically steers one player toward the ball or its home
// spot by synthesizing the W/A/S/D keycode bits the motion block consumes.
module cpu_player_driver
    import soccer_pkg::*;
#(
    parameter int unsigned KEY_SHIFT     = 6,
    parameter int unsigned DECIDE_PERIOD = 4,
    parameter int unsigned KICKOFF_DELAY = 60,
    parameter int unsigned DEADBAND      = 4,
    parameter int unsigned HOME_X        = DEF_HOME_X,
    parameter int unsigned HOME_Y        = DEF_HOME_Y,
    parameter int unsigned HALF_X        = FIELD_HALF_X
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic             centerPlayer,
    input  logic [POS_W-1:0] ballX,
    input  logic [POS_W-1:0] ballY,
    input  logic [POS_W-1:0] selfX,
    input  logic [POS_W-1:0] selfY,
    output logic [31:0]      keycode,
    output logic [1:0]       cpu_state
);

    localparam int unsigned CNT_MAX = (KICKOFF_DELAY > DECIDE_PERIOD) ? KICKOFF_DELAY : DECIDE_PERIOD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    cpu_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic             chase_c;
    logic [POS_W-1:0] tx_c;
    logic [POS_W-1:0] ty_c;
    logic             x_inc_c;
    logic             x_dec_c;
    logic             y_inc_c;
    logic             y_dec_c;
    logic [31:0]      key_c;

    // Mode and target selection for a decision taken this frame
    assign chase_c = ballX >= POS_W'(HALF_X);
    assign tx_c    = chase_c ? ballX : POS_W'(HOME_X);
    assign ty_c    = chase_c ? ballY : POS_W'(HOME_Y);

    axis_steer #(.W(POS_W)) u_steer_x (
        .target   (tx_c),
        .self     (selfX),
        .deadband (POS_W'(DEADBAND)),
        .inc      (x_inc_c),
        .dec      (x_dec_c)
    );

    axis_steer #(.W(POS_W)) u_steer_y (
        .target   (ty_c),
        .self     (selfY),
        .deadband (POS_W'(DEADBAND)),
        .inc      (y_inc_c),
        .dec      (y_dec_c)
    );

    always_comb begin
        key_c = '0;
        key_c[KEY_SHIFT + KEY_D] = x_inc_c;
        key_c[KEY_SHIFT + KEY_A] = x_dec_c;
        key_c[KEY_SHIFT + KEY_S] = y_inc_c;
        key_c[KEY_SHIFT + KEY_W] = y_dec_c;
    end

    // Control FSM with registered keycode; cnt paces kickoff and decisions
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            keycode <= '0;
            cnt     <= '0;
        end else if (!enable) begin
            state   <= IDLE;
            keycode <= '0;
            cnt     <= '0;
        end else if (centerPlayer) begin
            state   <= HOLD;
            keycode <= '0;
            cnt     <= CNT_W'(KICKOFF_DELAY - 1);
        end else begin
            case (state)
                IDLE: begin
                    state   <= HOLD;
                    keycode <= '0;
                    cnt     <= CNT_W'(KICKOFF_DELAY - 1);
                end
                HOLD, CHASE, RETURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (state == HOLD) begin
                            keycode <= '0;
                        end
                    end else begin
                        state   <= chase_c ? CHASE : RETURN;
                        keycode <= key_c;
                        cnt     <= CNT_W'(DECIDE_PERIOD - 1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    keycode <= '0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    assign cpu_state = 2'(state);

endmodule

// File: tb/tb_cpu_player_driver.sv
// Scoreboard bench for cpu_player_driver: directed kickoff/chase/return
// sequences with hand-computed keycodes, then random frames for invariants.
module tb_cpu_player_driver;
    import soccer_pkg::*;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        enable;
    logic        centerPlayer;
    logic [9:0]  ballX, ballY, selfX, selfY;
    logic [31:0] keycode;
    logic [1:0]  cpu_state;

    typedef struct packed {
        logic        chk;
        logic [7:0]  id;
        logic [1:0]  st;
        logic [31:0] kc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] K_NONE = 32'h000;
    localparam logic [31:0] K_D    = 32'h040;
    localparam logic [31:0] K_A    = 32'h100;
    localparam logic [31:0] K_WD   = 32'h240;
    localparam logic [31:0] K_WA   = 32'h300;
    localparam logic [31:0] K_SD   = 32'h0C0;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_HOLD = 2'd1;
    localparam logic [1:0]  S_CHSE = 2'd2;
    localparam logic [1:0]  S_RETN = 2'd3;

    cpu_player_driver dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .enable       (enable),
        .centerPlayer (centerPlayer),
        .ballX        (ballX),
        .ballY        (ballY),
        .selfX        (selfX),
        .selfY        (selfY),
        .keycode      (keycode),
        .cpu_state    (cpu_state)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic compare(input logic [7:0] id, input logic [31:0] kc, input logic [1:0] st);
        checks++;
        if (keycode !== kc || cpu_state !== st) begin
            errors++;
            $display("FAIL t%0d keycode=%h state=%0d expected keycode=%h state=%0d",
                     id, keycode, cpu_state, kc, st);
        end
    endtask

    // Queue the expected outputs for the coming edge, then advance one frame
    task automatic tick(input logic chk, input logic [31:0] kc, input logic [1:0] st, input logic [7:0] id);
        exp_q.push_back({chk, id, st, kc});
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic ticks(input int n, input logic [31:0] kc, input logic [1:0] st, input logic [7:0] id);
        for (int i = 0; i < n; i++) tick(1'b1, kc, st, id);
    endtask

    task automatic place(input int bx, input int by, input int sx, input int sy);
        ballX = 10'(bx);
        ballY = 10'(by);
        selfX = 10'(sx);
        selfY = 10'(sy);
    endtask

    // Monitor: pops one expectation per edge and checks keycode invariants
    always @(posedge frame_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) compare(mon_e.id, mon_e.kc, mon_e.st);
        end
        checks++;
        if ((keycode[9] & keycode[7]) || (keycode[8] & keycode[6]) || ((keycode & ~32'h3C0) != 32'h0)) begin
            errors++;
            $display("FAIL invariant keycode=%h required no W&S, no A&D, only bits 9:6", keycode);
        end
    end

    initial begin
        Reset        = 1'b1;
        enable       = 1'b0;
        centerPlayer = 1'b0;
        place(0, 0, 0, 0);
        #1;
        compare(8'd0, K_NONE, S_IDLE);
        ticks(2, K_NONE, S_IDLE, 8'd0);
        enable = 1'b1;
        ticks(1, K_NONE, S_IDLE, 8'd0);

        // Test 1: release goes to HOLD; async reset mid-frame clears at once
        Reset = 1'b0;
        ticks(4, K_NONE, S_HOLD, 8'd1);
        #2 Reset = 1'b1;
        #1 compare(8'd1, K_NONE, S_IDLE);
        ticks(1, K_NONE, S_IDLE, 8'd1);
        Reset = 1'b0;
        ticks(1, K_NONE, S_HOLD, 8'd1);

        // Test 2: kickoff then CHASE toward (500,100) from (430,240)
        place(500, 100, 430, 240);
        centerPlayer = 1'b1;
        ticks(1, K_NONE, S_HOLD, 8'd2);
        centerPlayer = 1'b0;
        ticks(59, K_NONE, S_HOLD, 8'd2);
        ticks(1, K_WD, S_CHSE, 8'd2);
        ticks(3, K_WD, S_CHSE, 8'd2);

        // Test 3: ball on own half -> RETURN home, arrival clears keys
        place(100, 240, 300, 240);
        ticks(1, K_D, S_RETN, 8'd3);
        place(100, 240, 426, 240);
        ticks(3, K_D, S_RETN, 8'd3);
        ticks(1, K_NONE, S_RETN, 8'd3);
        place(100, 240, 428, 242);
        ticks(4, K_NONE, S_RETN, 8'd3);

        // Test 4: overshoot between decisions is ignored until next decision
        place(500, 240, 430, 240);
        ticks(3, K_NONE, S_RETN, 8'd4);
        ticks(1, K_D, S_CHSE, 8'd4);
        place(500, 240, 520, 240);
        ticks(3, K_D, S_CHSE, 8'd4);
        ticks(1, K_A, S_CHSE, 8'd4);

        // Test 5: re-center during CHASE restarts kickoff
        centerPlayer = 1'b1;
        ticks(1, K_NONE, S_HOLD, 8'd5);
        centerPlayer = 1'b0;
        ticks(59, K_NONE, S_HOLD, 8'd5);
        ticks(1, K_A, S_CHSE, 8'd5);
        place(400, 100, 520, 240);
        ticks(3, K_A, S_CHSE, 8'd5);
        ticks(1, K_WA, S_CHSE, 8'd5);
        place(600, 400, 520, 240);
        ticks(3, K_WA, S_CHSE, 8'd5);
        ticks(1, K_SD, S_CHSE, 8'd5);

        // Test 6: enable dropped in RETURN, then re-raised for full kickoff
        place(100, 240, 300, 240);
        ticks(3, K_SD, S_CHSE, 8'd6);
        ticks(1, K_D, S_RETN, 8'd6);
        enable = 1'b0;
        ticks(1, K_NONE, S_IDLE, 8'd6);
        ticks(2, K_NONE, S_IDLE, 8'd6);
        enable = 1'b1;
        ticks(1, K_NONE, S_HOLD, 8'd6);
        ticks(59, K_NONE, S_HOLD, 8'd6);
        ticks(1, K_D, S_RETN, 8'd6);

        // Random frames: only the monitor invariants apply
        for (int i = 0; i < 10000; i++) begin
            place(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            enable       = ($urandom_range(0, 99) != 0);
            centerPlayer = ($urandom_range(0, 199) == 0);
            tick(1'b0, K_NONE, S_IDLE, 8'd7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
